// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit
// Resolves taken branches at the EX/MEM boundary and drives the fetch-stage
// PC-select inputs. A taken branch is latched, held as a redirect request
// until fetch accepts it, and then followed by FLUSH_CYCLES cycles of squash.
//
// Ports
//   clk, reset        core clock, synchronous active-high reset
//   Br_Valid          branch present at EX/MEM this cycle
//   Uncond_Branch     B-type, always taken
//   Branch            CBZ-type, taken when Zero=1
//   Branch_NZ         CBNZ-type, taken when Zero=0
//   Zero              ALU zero flag
//   Br_PC             branch instruction address
//   Br_Offset         sign-extended word offset
//   Fetch_Stall       fetch cannot load a new PC this cycle
//   PC_Source         1 = fetch selects Branch_Target
//   Branch_Target     registered redirect address
//   Flush             squash IF/ID and ID/EX
//   Busy              unit is in REDIRECT or FLUSH
//   Taken_Count       saturating count of accepted redirects
module branch_redirect_unit #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Br_Valid,
  input  logic        Uncond_Branch,
  input  logic        Branch,
  input  logic        Branch_NZ,
  input  logic        Zero,
  input  logic [63:0] Br_PC,
  input  logic [63:0] Br_Offset,
  input  logic        Fetch_Stall,
  output logic        PC_Source,
  output logic [63:0] Branch_Target,
  output logic        Flush,
  output logic        Busy,
  output logic [31:0] Taken_Count
);

  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

  localparam logic [3:0] LP_FLUSH = 4'(FLUSH_CYCLES);

  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        w_taken, w_latch, w_accept;
  logic [63:0] w_target;
  logic        r_pc_source, r_flush, r_busy;
  logic [63:0] r_target;
  logic [31:0] r_taken_cnt;

  assign w_taken  = Br_Valid & (Uncond_Branch | (Branch & Zero) | (Branch_NZ & ~Zero));
  // Offset is in instruction words; wrap-around is intentional and silent.
  assign w_target = Br_PC + (Br_Offset << 2);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_latch    = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_taken) begin
          w_latch = 1'b1;
          w_next  = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        // Stalled fetch: hold everything until the redirect is taken up.
        if (!Fetch_Stall) begin
          w_accept   = 1'b1;
          w_cnt_next = LP_FLUSH;
          w_next     = (LP_FLUSH != 4'd0) ? S_FLUSH : S_IDLE;
        end
      end
      S_FLUSH: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_target    <= 64'd0;
      r_taken_cnt <= 32'd0;
      r_pc_source <= 1'b0;
      r_flush     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) r_target <= w_target;
      if (w_accept && (r_taken_cnt != 32'hFFFF_FFFF)) r_taken_cnt <= r_taken_cnt + 32'd1;
      // Outputs are registered from the next state so they line up with it.
      r_pc_source <= (w_next == S_REDIRECT);
      r_flush     <= (w_next != S_IDLE);
      r_busy      <= (w_next != S_IDLE);
    end
  end

  assign PC_Source     = r_pc_source;
  assign Branch_Target = r_target;
  assign Flush         = r_flush;
  assign Busy          = r_busy;
  assign Taken_Count   = r_taken_cnt;

endmodule

// File: tb/tb_branch_redirect_unit.sv
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Br_Valid = 1'b0, Uncond_Branch = 1'b0, Branch = 1'b0, Branch_NZ = 1'b0, Zero = 1'b0;
  logic [63:0] Br_PC = '0, Br_Offset = '0;
  logic        Fetch_Stall = 1'b0;

  logic        pcs [2];
  logic [63:0] tgt [2];
  logic        fl  [2];
  logic        bsy [2];
  logic [31:0] cnt [2];

  always #5 clk = ~clk;

  branch_redirect_unit #(.FLUSH_CYCLES(2)) u_fc2 (
    .clk(clk), .reset(reset), .Br_Valid(Br_Valid), .Uncond_Branch(Uncond_Branch),
    .Branch(Branch), .Branch_NZ(Branch_NZ), .Zero(Zero), .Br_PC(Br_PC),
    .Br_Offset(Br_Offset), .Fetch_Stall(Fetch_Stall), .PC_Source(pcs[0]),
    .Branch_Target(tgt[0]), .Flush(fl[0]), .Busy(bsy[0]), .Taken_Count(cnt[0]));

  branch_redirect_unit #(.FLUSH_CYCLES(0)) u_fc0 (
    .clk(clk), .reset(reset), .Br_Valid(Br_Valid), .Uncond_Branch(Uncond_Branch),
    .Branch(Branch), .Branch_NZ(Branch_NZ), .Zero(Zero), .Br_PC(Br_PC),
    .Br_Offset(Br_Offset), .Fetch_Stall(Fetch_Stall), .PC_Source(pcs[1]),
    .Branch_Target(tgt[1]), .Flush(fl[1]), .Busy(bsy[1]), .Taken_Count(cnt[1]));

  // Reference model: a pending-redirect flag plus the number of squash cycles
  // still owed after fetch accepts the redirect.
  int          fc     [2] = '{2, 0};
  logic        m_pend [2];
  int          m_left [2];
  logic [63:0] m_tgt  [2];
  longint      m_cnt  [2];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_edge();
    logic tk;
    tk = Br_Valid && (Uncond_Branch || (Branch && Zero) || (Branch_NZ && !Zero));
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pend[k] = 0; m_left[k] = 0; m_tgt[k] = 0; m_cnt[k] = 0;
      end else if (m_pend[k]) begin
        if (!Fetch_Stall) begin
          m_pend[k] = 0;
          m_left[k] = fc[k];
          if (m_cnt[k] < 64'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 1;
        end
      end else if (m_left[k] > 0) begin
        m_left[k] = m_left[k] - 1;
      end else if (tk) begin
        m_tgt[k]  = Br_PC + Br_Offset * 4;
        m_pend[k] = 1;
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("pc_source[%0d]", k), 64'(pcs[k]), 64'(m_pend[k]));
      chk($sformatf("flush[%0d]", k), 64'(fl[k]), 64'(m_pend[k] || m_left[k] > 0));
      chk($sformatf("busy[%0d]", k), 64'(bsy[k]), 64'(m_pend[k] || m_left[k] > 0));
      chk($sformatf("target[%0d]", k), tgt[k], m_tgt[k]);
      chk($sformatf("taken_cnt[%0d]", k), 64'(cnt[k]), 64'(m_cnt[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic br(input logic v, input logic u, input logic b, input logic nz,
                    input logic z, input logic [63:0] pc, input logic [63:0] off);
    Br_Valid = v; Uncond_Branch = u; Branch = b; Branch_NZ = nz; Zero = z;
    Br_PC = pc; Br_Offset = off;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_left[k] = 0; m_tgt[k] = 0; m_cnt[k] = 0;
    end
    #2;
    // Reset held for two cycles, then a not-taken CBZ.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    br(1, 0, 1, 0, 0, 64'h2000, 64'h8);
    tick(); tick();
    chk("nt_target", tgt[0], 64'h0);
    chk("nt_busy", 64'(bsy[0]), 64'h0);

    // Unconditional branch, no stall.
    br(1, 1, 0, 0, 0, 64'h1000, 64'h10);
    tick();
    br(0, 0, 0, 0, 0, 64'h0, 64'h0);
    chk("b_pcs", 64'(pcs[0]), 64'h1);
    chk("b_target", tgt[0], 64'h1040);
    repeat (4) tick();
    chk("b_count", 64'(cnt[0]), 64'h1);

    // CBNZ with wrap-around target and a 3-cycle fetch stall.
    br(1, 0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h4);
    Fetch_Stall = 1'b1;
    tick();
    br(0, 0, 0, 0, 0, 64'h0, 64'h0);
    chk("wrap_target", tgt[0], 64'h8);
    repeat (3) tick();
    chk("stall_pcs", 64'(pcs[0]), 64'h1);
    Fetch_Stall = 1'b0;
    repeat (4) tick();

    // Wrong-path branches during REDIRECT and FLUSH are ignored.
    br(1, 1, 0, 0, 0, 64'h4000, 64'h1);
    tick();
    br(1, 1, 0, 0, 0, 64'h9000, 64'h100);
    repeat (3) tick();
    br(0, 0, 0, 0, 0, 64'h0, 64'h0);
    tick();
    chk("wp_target", tgt[0], 64'h4004);
    chk("wp_count", 64'(cnt[0]), 64'h3);

    // Reset in the second FLUSH cycle of the FLUSH_CYCLES=2 unit.
    br(1, 1, 0, 0, 0, 64'h100, 64'h2);
    tick();
    br(0, 0, 0, 0, 0, 64'h0, 64'h0);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy", 64'(bsy[0]), 64'h0);
    chk("rst_count", 64'(cnt[0]), 64'h0);

    // Reset while stalled in REDIRECT.
    br(1, 1, 0, 0, 0, 64'h300, 64'h3);
    Fetch_Stall = 1'b1;
    tick();
    br(0, 0, 0, 0, 0, 64'h0, 64'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    Fetch_Stall = 1'b0;
    chk("rst_stall_target", tgt[0], 64'h0);

    // Back-to-back CBZ branches two cycles apart.
    br(1, 0, 1, 0, 1, 64'h500, 64'h1);
    tick();
    br(0, 0, 0, 0, 0, 64'h0, 64'h0);
    tick();
    br(1, 0, 1, 0, 1, 64'h600, 64'h2);
    tick();
    br(0, 0, 0, 0, 0, 64'h0, 64'h0);
    tick(); tick();
    chk("b2b_count", 64'(cnt[1]), 64'h2);
    chk("b2b_target", tgt[1], 64'h608);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 99) == 0);
      Br_Valid      = $urandom_range(0, 1);
      Uncond_Branch = ($urandom_range(0, 3) == 0);
      Branch        = $urandom_range(0, 1);
      Branch_NZ     = $urandom_range(0, 1);
      Zero          = $urandom_range(0, 1);
      Br_PC         = {$urandom, $urandom};
      Br_Offset     = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom}
                                                  : 64'($signed(12'($urandom)));
      Fetch_Stall   = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Resolves taken branches for the 64-bit pipelined ARM core and drives the PC-select inputs (PC_Source, Branch_Target) of the fetch-stage PC multiplexer. It samples branch information from the EX/MEM boundary, evaluates the branch condition, and computes the target. It holds the redirect request until fetch accepts it, then flushes the wrong-path instructions for a programmable number of cycles. It is the producer side of the PC-select interface; the fetch mux is the consumer.

## Interface
Parameters:
- FLUSH_CYCLES, default 2: cycles of Flush asserted after the redirect is accepted. Legal range is 0..15.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Br_Valid  input  1  a branch instruction is present at EX/MEM this cycle.
- Uncond_Branch  input  1  B-type branch, always taken.
- Branch  input  1  CBZ-type branch, taken when Zero=1.
- Branch_NZ  input  1  CBNZ-type branch, taken when Zero=0.
- Zero  input  1  ALU zero flag for the branch operand.
- Br_PC  input  64  address of the branch instruction.
- Br_Offset  input  64  sign-extended immediate, counted in instruction words.
- Fetch_Stall  input  1  fetch cannot load a new PC this cycle.
- PC_Source  output  1  1 = fetch must select Branch_Target; 0 = sequential PC.
- Branch_Target  output  64  registered redirect address.
- Flush  output  1  squash the IF/ID and ID/EX contents.
- Busy  output  1  the unit is in REDIRECT or FLUSH.
- Taken_Count  output  32  saturating count of accepted taken branches.

## Operation
- taken = Br_Valid & (Uncond_Branch | (Branch & Zero) | (Branch_NZ & ~Zero)).
- Target = Br_PC + (Br_Offset << 2), computed modulo 2^64. Wrap-around is silent, with no overflow flag.
- The state machine has three states: IDLE, REDIRECT and FLUSH.
  - IDLE: if taken is sampled, latch the target into Branch_Target and go to REDIRECT. Otherwise stay in IDLE; not-taken branches cause no action.
  - REDIRECT: PC_Source=1, Flush=1, Busy=1.
    - If Fetch_Stall=1, stay in REDIRECT and hold every output and Branch_Target unchanged.
    - If Fetch_Stall=0, fetch loads Branch_Target at this edge. Increment Taken_Count (saturate at 0xFFFFFFFF). Load the flush counter with FLUSH_CYCLES.
    - Then go to FLUSH if FLUSH_CYCLES>0, otherwise to IDLE.
  - FLUSH: PC_Source=0, Flush=1, Busy=1. Decrement the counter each cycle and go to IDLE when it reaches 1. Fetch_Stall has no effect in this state.
- Br_Valid is ignored in REDIRECT and FLUSH, because those branches are on the wrong path.
- Branch_Target keeps its last value in IDLE. It changes only when a new taken branch is latched.
- If more than one of the branch-type inputs is set, the taken equation above decides; there is no priority encoding.

## Timing
- Reset values: state IDLE, PC_Source 0, Branch_Target 0, Flush 0, Busy 0, Taken_Count 0, flush counter 0.
- Reset mid-operation (in REDIRECT or FLUSH): the pending redirect is abandoned. All outputs take their reset values in the cycle after the reset edge, and Taken_Count is not incremented.
- Latency: a taken branch sampled at edge N gives PC_Source=1 and a valid Branch_Target in cycle N+1. All outputs are registered; there is no combinational path from any input to any output.
- With no stall, PC_Source is high for exactly 1 cycle and Flush is high for 1+FLUSH_CYCLES consecutive cycles.
- Each stall cycle in REDIRECT adds one cycle to both PC_Source and Flush.
- Br_Valid in the first IDLE cycle after FLUSH is accepted normally, so back-to-back redirects are separated by at least 1+FLUSH_CYCLES busy cycles plus one cycle.

## Test plan
- Reset and not-taken: reset held for 2 cycles, then Br_Valid=1, Branch=1, Zero=0 → PC_Source, Flush and Busy stay 0, Branch_Target=0, Taken_Count=0.
- Unconditional branch: Br_PC=0x1000, Br_Offset=0x10, Uncond_Branch=1 → next cycle PC_Source=1 and Branch_Target=0x1040. PC_Source is high for 1 cycle, Flush for 3 cycles (FLUSH_CYCLES=2), then Taken_Count=1.
- Stall and wrap: CBNZ with Zero=0, Br_PC=0xFFFFFFFFFFFFFFF8, Br_Offset=4, and Fetch_Stall=1 for 3 cycles.
  - Branch_Target=0x8, and PC_Source is held for 4 cycles.
  - Flush lasts 6 cycles.
- Wrong-path suppression: a taken branch, then Br_Valid=1 with Uncond_Branch=1 and a different target during REDIRECT and during each FLUSH cycle → Branch_Target is unchanged and Taken_Count increments only once.
- Reset mid-operation: reset asserted in the second FLUSH cycle (or while stalled in REDIRECT) → the following cycle shows PC_Source=0, Flush=0, Busy=0, Branch_Target=0, Taken_Count=0.
- FLUSH_CYCLES=0, back-to-back: two taken CBZ branches (Zero=1) issued 2 cycles apart → two 1-cycle redirects, Flush high only in the REDIRECT cycles, Taken_Count=2.
